mem_req_ctrl: RTL

//  Request front-end between the pipeline memory stage and mem_system (cache + four-bank memory).

---
 rtl/mem_req_ctrl_pkg.sv | 19 +
 rtl/sat_cnt.sv | 20 ++
 rtl/mem_req_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// Shared encodings for the pipeline-to-mem_system request front-end.
// Holds the state codes, the latched operation layout and the request legality rule.
package mem_req_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef struct packed {
        logic wr;
        logic rd;
    } mem_op_t;

    // Exactly one of load/store, to an even byte address.
    function automatic logic req_legal(input logic rd, input logic wr, input logic addr_lsb);
        return (rd ^ wr) & ~addr_lsb;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Enable-increment statistic counter that sticks at all-ones.
// Synchronous clear has priority over the increment.
module sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request front-end between the pipeline memory stage and mem_system.
// Latches one load/store, holds it toward mem_system until Done, then pulses pipe_done.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_rd,
    input  logic             pipe_wr,
    input  logic [15:0]      pipe_addr,
    input  logic [15:0]      pipe_wdata,
    output logic             pipe_stall,
    output logic             pipe_done,
    output logic [15:0]      pipe_rdata,
    output logic             pipe_err,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_done,
    input  logic             mem_stall,
    input  logic             mem_hit,
    input  logic             mem_err,
    output logic [CNT_W-1:0] stat_hits,
    output logic [CNT_W-1:0] stat_misses
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    mem_op_t     op_q, op_d;
    logic        err_q, err_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        hit_inc, miss_inc;

    // mem_system's Stall is informational; the handshake relies on Done alone.
    logic unused_mem_stall;
    assign unused_mem_stall = mem_stall;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        op_d     = op_q;
        err_d    = err_q;
        tcnt_d   = tcnt_q;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pipe_rd | pipe_wr) begin
                    if (req_legal(pipe_rd, pipe_wr, pipe_addr[0])) begin
                        addr_d  = pipe_addr;
                        wdata_d = pipe_wdata;
                        op_d    = '{wr: pipe_wr, rd: pipe_rd};
                        state_d = ST_BUSY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                err_d  = err_q | mem_err;
                tcnt_d = tcnt_q + 8'd1;
                if (mem_done) begin
                    if (op_q.rd) rdata_d = mem_rdata;
                    hit_inc  = mem_hit;
                    miss_inc = ~mem_hit;
                    state_d  = ST_DONE;
                end else if (tcnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                tcnt_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_q    <= op_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Done gating is combinational so mem_system drops back to idle instead of re-issuing.
    assign mem_rd     = (state_q == ST_BUSY) & op_q.rd & ~mem_done;
    assign mem_wr     = (state_q == ST_BUSY) & op_q.wr & ~mem_done;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign pipe_stall = ((state_q == ST_IDLE) & (pipe_rd | pipe_wr)) | (state_q == ST_BUSY);
    assign pipe_done  = (state_q == ST_DONE);
    assign pipe_err   = (state_q == ST_DONE) & err_q;
    assign pipe_rdata = rdata_q;

    sat_cnt #(.CNT_W(CNT_W)) u_hits (
        .clk (clk),
        .clr (rst),
        .en  (hit_inc),
        .cnt (stat_hits)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_misses (
        .clk (clk),
        .clr (rst),
        .en  (miss_inc),
        .cnt (stat_misses)
    );

endmodule
